// File: rtl/hack_rom_loader.sv
// Instruction memory and boot loader for the Hack CPU: receives a length-prefixed,
// XOR-checksummed program over a byte stream and holds the core in reset until it is valid.
module hack_rom_loader #(
    parameter int ADDR_W = 10
) (
    input  logic        CLK,
    input  logic        reset_n,
    input  logic        load_req,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    input  logic [14:0] pc,
    output logic [15:0] instruction,
    output logic        cpu_reset,
    output logic        busy,
    output logic        err,
    output logic [15:0] word_count,
    output logic [2:0]  fsm_state
);

    localparam int          DEPTH   = 2 ** ADDR_W;
    localparam logic [16:0] DEPTH_W = 17'(DEPTH);

    typedef enum logic [2:0] {
        S_WAIT   = 3'd0,
        S_LEN_HI = 3'd1,
        S_LEN_LO = 3'd2,
        S_DAT_HI = 3'd3,
        S_DAT_LO = 3'd4,
        S_CHK    = 3'd5,
        S_RUN    = 3'd6,
        S_ERR    = 3'd7
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [15:0]     len;
    logic [7:0]      hi;
    logic [ADDR_W:0] ptr;
    logic [7:0]      csum;
    logic [15:0]     mem [DEPTH];

    // Stream handshake: a byte moves on a cycle where rx_valid and rx_ready are both
    // high; rx_ready depends only on state, so stalls simply hold everything in place.
    logic            take;
    logic            load_start;
    logic [15:0]     len_rx;
    logic [ADDR_W:0] ptr_inc;
    logic            ptr_last;
    logic            chk_ok;
    logic            in_range;

    assign take       = rx_valid & rx_ready;
    assign load_start = load_req && (state == S_WAIT || state == S_RUN || state == S_ERR);
    assign len_rx     = {len[15:8], rx_data};
    assign ptr_inc    = ptr + 1'b1;
    assign ptr_last   = (16'(ptr_inc) == len);
    assign chk_ok     = (rx_data == csum);

    // State register
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_WAIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_WAIT, S_RUN, S_ERR: begin
                if (load_req) state_nxt = S_LEN_HI;
            end
            S_LEN_HI: begin
                if (take) state_nxt = S_LEN_LO;
            end
            S_LEN_LO: begin
                if (take) begin
                    if ({1'b0, len_rx} > DEPTH_W) state_nxt = S_ERR;
                    else if (len_rx == 16'd0)     state_nxt = S_CHK;
                    else                          state_nxt = S_DAT_HI;
                end
            end
            S_DAT_HI: begin
                if (take) state_nxt = S_DAT_LO;
            end
            S_DAT_LO: begin
                if (take) state_nxt = ptr_last ? S_CHK : S_DAT_HI;
            end
            S_CHK: begin
                if (take) state_nxt = chk_ok ? S_RUN : S_ERR;
            end
            default: state_nxt = S_WAIT;
        endcase
    end

    // Outputs are decoded from the state register only
    always_comb begin
        rx_ready  = 1'b0;
        busy      = 1'b0;
        cpu_reset = 1'b1;
        err       = 1'b0;
        fsm_state = state;
        case (state)
            S_LEN_HI, S_LEN_LO, S_DAT_HI, S_DAT_LO, S_CHK: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
            end
            S_RUN:   cpu_reset = 1'b0;
            S_ERR:   err       = 1'b1;
            default: ;
        endcase
    end

    // Frame datapath: length, pending high byte, write pointer, running XOR
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            len        <= '0;
            hi         <= '0;
            ptr        <= '0;
            csum       <= '0;
            word_count <= '0;
        end else if (load_start) begin
            ptr        <= '0;
            csum       <= '0;
            word_count <= '0;
        end else if (take) begin
            case (state)
                S_LEN_HI: begin
                    len[15:8] <= rx_data;
                    csum      <= csum ^ rx_data;
                end
                S_LEN_LO: begin
                    len[7:0] <= rx_data;
                    csum     <= csum ^ rx_data;
                end
                S_DAT_HI: begin
                    hi   <= rx_data;
                    csum <= csum ^ rx_data;
                end
                S_DAT_LO: begin
                    ptr  <= ptr_inc;
                    csum <= csum ^ rx_data;
                end
                S_CHK: begin
                    if (chk_ok) word_count <= len;
                end
                default: ;
            endcase
        end
    end

    // Memory is not reset; stale words stay hidden behind word_count
    always_ff @(posedge CLK) begin
        if (take && state == S_DAT_LO) begin
            mem[ptr[ADDR_W-1:0]] <= {hi, rx_data};
        end
    end

    // Zero-latency fetch; the full pc, including bits above ADDR_W, is range-checked
    assign in_range    = ({1'b0, pc} < word_count);
    assign instruction = in_range ? mem[pc[ADDR_W-1:0]] : 16'h0000;

endmodule

// File: tb/tb_hack_rom_loader.sv
// Directed bench for hack_rom_loader: frame loads, checksum/length errors, stalls,
// mid-load reset and reload, with a scoreboard on load completion and instruction fetch.
module tb_hack_rom_loader;

    localparam logic [2:0] ST_WAIT   = 3'd0;
    localparam logic [2:0] ST_LEN_HI = 3'd1;
    localparam logic [2:0] ST_LEN_LO = 3'd2;
    localparam logic [2:0] ST_DAT_HI = 3'd3;
    localparam logic [2:0] ST_DAT_LO = 3'd4;
    localparam logic [2:0] ST_CHK    = 3'd5;
    localparam logic [2:0] ST_RUN    = 3'd6;
    localparam logic [2:0] ST_ERR    = 3'd7;

    logic        CLK = 1'b0;
    logic        reset_n;
    logic        load_req;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [14:0] pc;
    logic [15:0] instruction;
    logic        cpu_reset;
    logic        busy;
    logic        err;
    logic [15:0] word_count;
    logic [2:0]  fsm_state;

    hack_rom_loader #(.ADDR_W(10)) dut (
        .CLK         (CLK),
        .reset_n     (reset_n),
        .load_req    (load_req),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .pc          (pc),
        .instruction (instruction),
        .cpu_reset   (cpu_reset),
        .busy        (busy),
        .err         (err),
        .word_count  (word_count),
        .fsm_state   (fsm_state)
    );

    // Clock and watchdog
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int checks = 0;
    int errors = 0;

    // Expected load-completion record {cpu_reset, err, word_count}
    logic [17:0] exp_q[$];
    logic [15:0] exp_instr_q[$];
    logic [17:0] exp_done;
    logic [15:0] exp_instr;
    logic        prev_busy = 1'b0;
    logic        pc_chk = 1'b0;

    logic [7:0] f1[$]    = '{8'h00, 8'h02, 8'h00, 8'h10, 8'hEC, 8'h10, 8'hEE};
    logic [7:0] f_bad[$] = '{8'h00, 8'h02, 8'h00, 8'h10, 8'hEC, 8'h10, 8'hEF};
    logic [2:0] f1_states[7] = '{ST_LEN_LO, ST_DAT_HI, ST_DAT_LO, ST_DAT_HI,
                                 ST_DAT_LO, ST_CHK, ST_RUN};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: samples after inputs settle, away from the rising edge
    always @(negedge CLK) begin
        #2;
        if (prev_busy && !busy) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL done_unexpected actual=load_end required=none_pending");
            end else begin
                exp_done = exp_q.pop_front();
                check("done_cpu_reset", 32'(cpu_reset), 32'(exp_done[17]));
                check("done_err", 32'(err), 32'(exp_done[16]));
                check("done_word_count", 32'(word_count), 32'(exp_done[15:0]));
            end
        end
        prev_busy = busy;
        if (pc_chk) begin
            if (exp_instr_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL fetch_unexpected actual=%0h required=none_pending", instruction);
            end else begin
                exp_instr = exp_instr_q.pop_front();
                check($sformatf("instr_pc_%0h", pc), 32'(instruction), 32'(exp_instr));
            end
        end
    end

    // Driver tasks; all start and end on a falling edge
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 50) begin
            @(negedge CLK);
            n++;
        end
        if (!rx_ready) begin
            checks++;
            errors++;
            $display("FAIL rx_ready_timeout actual=0 required=1 byte=%0h", b);
        end
        @(negedge CLK);
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] f[$]);
        foreach (f[i]) send_byte(f[i]);
    endtask

    task automatic pulse_load();
        load_req = 1'b1;
        @(negedge CLK);
        load_req = 1'b0;
    endtask

    task automatic read_pc(input logic [14:0] p, input logic [15:0] exp);
        pc     = p;
        pc_chk = 1'b1;
        exp_instr_q.push_back(exp);
        @(negedge CLK);
        pc_chk = 1'b0;
    endtask

    initial begin
        reset_n  = 1'b0;
        load_req = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        pc       = 15'd0;
        repeat (2) @(negedge CLK);
        check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        check("rst_rx_ready", 32'(rx_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_word_count", 32'(word_count), 32'd0);
        check("rst_state", 32'(fsm_state), 32'(ST_WAIT));
        check("rst_instr", 32'(instruction), 32'h0);
        reset_n = 1'b1;
        @(negedge CLK);

        // Good two-word frame
        exp_q.push_back({1'b0, 1'b0, 16'd2});
        pulse_load();
        send_frame(f1);
        check("t1_state", 32'(fsm_state), 32'(ST_RUN));
        read_pc(15'd0, 16'h0010);
        read_pc(15'd1, 16'hEC10);
        read_pc(15'd2, 16'h0000);
        read_pc(15'h4000, 16'h0000);

        // Bad checksum
        exp_q.push_back({1'b1, 1'b1, 16'd0});
        pulse_load();
        send_frame(f_bad);
        check("t2_err", 32'(err), 32'd1);
        check("t2_state", 32'(fsm_state), 32'(ST_ERR));
        read_pc(15'd0, 16'h0000);
        pulse_load();
        check("t2_err_cleared", 32'(err), 32'd0);
        check("t2_busy", 32'(busy), 32'd1);

        // Oversize length (1025 > 1024)
        exp_q.push_back({1'b1, 1'b1, 16'd0});
        send_byte(8'h04);
        send_byte(8'h01);
        check("t3_state", 32'(fsm_state), 32'(ST_ERR));
        check("t3_rx_ready", 32'(rx_ready), 32'd0);
        check("t3_mem0", 32'(dut.mem[0]), 32'h0010);
        check("t3_mem1", 32'(dut.mem[1]), 32'hEC10);

        // Length exactly DEPTH is accepted, then aborted by reset
        pulse_load();
        send_byte(8'h04);
        send_byte(8'h00);
        check("t3_depth_state", 32'(fsm_state), 32'(ST_DAT_HI));
        exp_q.push_back({1'b1, 1'b0, 16'd0});
        reset_n = 1'b0;
        @(negedge CLK);
        check("t3_reset_state", 32'(fsm_state), 32'(ST_WAIT));
        reset_n = 1'b1;
        @(negedge CLK);

        // Good frame with 5-cycle stalls between bytes
        exp_q.push_back({1'b0, 1'b0, 16'd2});
        pulse_load();
        for (int i = 0; i < 7; i++) begin
            send_byte(f1[i]);
            for (int s = 0; s < 5; s++) begin
                check($sformatf("t4_stall_state_%0d_%0d", i, s), 32'(fsm_state), 32'(f1_states[i]));
                check($sformatf("t4_stall_ready_%0d_%0d", i, s), 32'(rx_ready), (i < 6) ? 32'd1 : 32'd0);
                @(negedge CLK);
            end
        end
        read_pc(15'd0, 16'h0010);
        read_pc(15'd1, 16'hEC10);

        // Reset in the middle of a three-word load, then reload
        pulse_load();
        check("t5_wc_during_load", 32'(word_count), 32'd0);
        check("t5_cpu_reset_during_load", 32'(cpu_reset), 32'd1);
        read_pc(15'd0, 16'h0000);
        send_byte(8'h00);
        send_byte(8'h03);
        send_byte(8'hA1);
        send_byte(8'hB2);
        send_byte(8'hC3);
        check("t5_state_dat_lo", 32'(fsm_state), 32'(ST_DAT_LO));
        exp_q.push_back({1'b1, 1'b0, 16'd0});
        reset_n = 1'b0;
        @(negedge CLK);
        check("t5_state", 32'(fsm_state), 32'(ST_WAIT));
        check("t5_cpu_reset", 32'(cpu_reset), 32'd1);
        check("t5_word_count", 32'(word_count), 32'd0);
        check("t5_rx_ready", 32'(rx_ready), 32'd0);
        reset_n = 1'b1;
        @(negedge CLK);
        exp_q.push_back({1'b0, 1'b0, 16'd2});
        pulse_load();
        send_frame(f1);
        read_pc(15'd0, 16'h0010);
        read_pc(15'd1, 16'hEC10);
        read_pc(15'd2, 16'h0000);

        // load_req together with rx_valid in RUN, then an empty program
        load_req = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'h55;
        @(negedge CLK);
        load_req = 1'b0;
        rx_valid = 1'b0;
        check("t6_cpu_reset", 32'(cpu_reset), 32'd1);
        check("t6_state", 32'(fsm_state), 32'(ST_LEN_HI));
        check("t6_word_count", 32'(word_count), 32'd0);
        exp_q.push_back({1'b0, 1'b0, 16'd0});
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        check("t6_run_state", 32'(fsm_state), 32'(ST_RUN));
        read_pc(15'd0, 16'h0000);
        read_pc(15'd1, 16'h0000);
        read_pc(15'h7FFF, 16'h0000);

        repeat (3) @(negedge CLK);
        check("done_queue_empty", 32'(exp_q.size()), 32'd0);
        check("fetch_queue_empty", 32'(exp_instr_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
